pq_stream_adapter: RTL and testbench
====================================

PQ_STREAM_ADAPTER -- requirements
Module: pq_stream_adapter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, width of keys (min-priority, smaller = higher priority).
REQ-002 SHALL have parameter QUEUE_SIZE, default 4, capacity of the attached queue.
REQ-003 SHALL have parameter SETTLE_CYCLES, default 1, idle cycles enforced after every queue operation; legal range 1..15.
REQ-004 SHALL have ports: CLK input 1 clock; RSTn input 1 asynchronous active-low reset.
REQ-005 SHALL have ports: s_valid input 1, s_ready output 1, s_data input DATA_WIDTH; push stream.
REQ-006 SHALL have ports: m_valid output 1, m_ready input 1, m_data output DATA_WIDTH; pop stream.
REQ-007 SHALL have ports: pq_wrt output 1, pq_read output 1, pq_data output DATA_WIDTH; commands to queue.
REQ-008 SHALL have ports: pq_full input 1, pq_empty input 1, pq_head input DATA_WIDTH; queue status and head key.
REQ-009 SHALL have ports: o_count output $clog2(QUEUE_SIZE+1), o_busy output 1, o_err output 1 (sticky).

Function
REQ-010 SHALL implement FSM states IDLE and SETTLE; commands issue only in IDLE.
REQ-011 SHALL move IDLE->SETTLE in the cycle any command issues, load settle counter with SETTLE_CYCLES, return to IDLE when counter reaches 0.
REQ-012 SHALL assert o_busy exactly while in SETTLE.
REQ-013 SHALL drive s_ready = IDLE && (!pq_full || pop accepted same cycle).
REQ-014 SHALL issue PUSH (pq_wrt=1, pq_read=0, pq_data=s_data) on push handshake without pop handshake.
REQ-015 SHALL issue POP (pq_wrt=0, pq_read=1) on pop-side transfer from queue without push handshake; never when pq_empty.
REQ-016 SHALL issue REPLACE (pq_wrt=1, pq_read=1) when push and pop coincide and !pq_empty; if pq_empty only PUSH issues.
REQ-017 SHALL hold pq_wrt/pq_read as single-cycle pulses, 0 in all other cycles; pq_data = s_data (don't-care when pq_wrt=0).
REQ-018 SHALL update o_count: +1 PUSH, -1 POP, unchanged REPLACE; saturating at 0 and QUEUE_SIZE.
REQ-019 SHALL set o_err when, in IDLE, pq_empty != (o_count==0) or pq_full != (o_count==QUEUE_SIZE); cleared only by reset.
REQ-020 SHALL never drop or duplicate a key: every accepted s_data appears exactly once on m_data, in non-decreasing order relative to keys present at pop time.

Reset
REQ-021 SHALL on RSTn low, asynchronously: state IDLE, settle counter 0, o_count 0, o_err 0, m_valid 0, m_data 0, pq_wrt 0, pq_read 0.
REQ-022 SHALL, for reset asserted mid-SETTLE or with m_valid high, discard the pending buffer and return to IDLE; queue reset is the integrator's responsibility.

Configuration
REQ-023 SHALL support macro PQ_PREFETCH_EN.
REQ-024 Without PQ_PREFETCH_EN: m_valid = IDLE && !pq_empty, m_data = pq_head combinationally, POP issues on m_valid && m_ready.
REQ-025 With PQ_PREFETCH_EN: one-entry registered output buffer; when buffer empty (or emptying via m_ready) in IDLE and !pq_empty, SHALL capture pq_head into m_data and issue POP same cycle; m_valid, m_data registered and held stable until m_ready.
REQ-026 With PQ_PREFETCH_EN the buffered key SHALL NOT be overtaken by later smaller pushes; o_count SHALL exclude the buffered entry.

Structure
REQ-027 SHALL place in shared package pq_pkg: enum pq_op_e {OP_NONE, OP_PUSH, OP_POP, OP_REPLACE}, enum adapter_state_e {IDLE, SETTLE}, SETTLE counter width constant (4).
REQ-028 SHALL implement the prefetch buffer as sub-module pq_out_buf (valid/ready one-entry register), instantiated only under PQ_PREFETCH_EN.

Verification
REQ-029 Push 7,3,9 into empty queue (SETTLE_CYCLES=1) -> pq_wrt pulses at cycles 0,2,4; s_ready low cycles 1,3,5; o_count 3.
REQ-030 Then pop three with m_ready=1 -> m_data 3,7,9 in order; o_count 0; m_valid 0 after; no pq_read while pq_empty.
REQ-031 Fill to QUEUE_SIZE=4 with 5,6,7,8; hold s_valid with 1 and m_ready=1 -> REPLACE issued, m_data=5, o_count stays 4; s_ready low when full and m_ready=0.
REQ-032 Empty queue, s_valid=1 with m_ready=1 -> PUSH only, pq_read=0, o_count 1.
REQ-033 Force pq_empty=1 with o_count=2 in IDLE -> o_err=1 next cycle and stays 1 until RSTn.
REQ-034 PQ_PREFETCH_EN: push 4, stall m_ready, push 2 -> m_data holds 4 stable; release -> 4 then 2; assert RSTn mid-SETTLE -> all outputs at reset values.

Source files
------------

// File: rtl/pq_pkg.sv
// Shared types for the priority-queue stream adapter: queue command
// encoding, adapter FSM states and the settle counter width.
package pq_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        OP_NONE,
        OP_PUSH,
        OP_POP,
        OP_REPLACE
    } pq_op_e;

    typedef enum logic {
        IDLE,
        SETTLE
    } adapter_state_e;

    function automatic pq_op_e op_decode(input logic push, input logic pop);
        pq_op_e op;
        op = OP_NONE;
        unique case (1'b1)
            (push && pop):  op = OP_REPLACE;
            (push && !pop): op = OP_PUSH;
            (!push && pop): op = OP_POP;
            default:        op = OP_NONE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/pq_out_buf.sv
// One-entry valid/ready register slice holding the prefetched head key
// so m_valid/m_data are registered and stable until accepted.
module pq_out_buf #(
    parameter int DW = 16
) (
    input  logic          CLK,
    input  logic          RSTn,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [DW-1:0] in_data_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [DW-1:0] out_data_o
);

    logic          valid_q, valid_d;
    logic [DW-1:0] data_q, data_d;

    assign in_ready_o  = !valid_q || out_ready_i;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (in_valid_i && in_ready_o) begin
            valid_d = 1'b1;
            data_d  = in_data_i;
        end else if (out_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/pq_stream_adapter.sv
// Stream front-end for a min-priority queue with enforced settle time.
// Define PQ_PREFETCH_EN for a registered one-entry output buffer.
module pq_stream_adapter
    import pq_pkg::*;
#(
    parameter int DATA_WIDTH    = 16,
    parameter int QUEUE_SIZE    = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                              CLK,
    input  logic                              RSTn,
    input  logic                              s_valid,
    output logic                              s_ready,
    input  logic [DATA_WIDTH-1:0]             s_data,
    output logic                              m_valid,
    input  logic                              m_ready,
    output logic [DATA_WIDTH-1:0]             m_data,
    output logic                              pq_wrt,
    output logic                              pq_read,
    output logic [DATA_WIDTH-1:0]             pq_data,
    input  logic                              pq_full,
    input  logic                              pq_empty,
    input  logic [DATA_WIDTH-1:0]             pq_head,
    output logic [$clog2(QUEUE_SIZE+1)-1:0]   o_count,
    output logic                              o_busy,
    output logic                              o_err
);

    localparam int CW = $clog2(QUEUE_SIZE + 1);
    localparam logic [CW-1:0]    QMAX      = CW'(QUEUE_SIZE);
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES);

    adapter_state_e   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CW-1:0]    count_q, count_d;
    logic             err_q, err_d;

    logic   idle;
    logic   fetch;
    logic   push;
    pq_op_e op;

    // Commands are suppressed while reset is held, not just after it.
    assign idle = RSTn && (state_q == IDLE);

`ifdef PQ_PREFETCH_EN
    logic buf_ready;

    assign fetch = idle && !pq_empty && buf_ready;

    pq_out_buf #(
        .DW (DATA_WIDTH)
    ) u_out_buf (
        .CLK         (CLK),
        .RSTn        (RSTn),
        .in_valid_i  (fetch),
        .in_ready_o  (buf_ready),
        .in_data_i   (pq_head),
        .out_valid_o (m_valid),
        .out_ready_i (m_ready),
        .out_data_o  (m_data)
    );
`else
    assign m_valid = idle && !pq_empty;
    assign m_data  = RSTn ? pq_head : '0;
    assign fetch   = m_valid && m_ready;
`endif

    assign s_ready = idle && (!pq_full || fetch);
    assign push    = s_valid && s_ready;
    assign op      = op_decode(push, fetch);

    assign pq_wrt  = (op == OP_PUSH) || (op == OP_REPLACE);
    assign pq_read = (op == OP_POP) || (op == OP_REPLACE);
    assign pq_data = s_data;

    assign o_count = count_q;
    assign o_busy  = (state_q == SETTLE);
    assign o_err   = err_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (op != OP_NONE) begin
                    state_d = SETTLE;
                    cnt_d   = SETTLE_LD;
                end
            end
            SETTLE: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        count_d = count_q;
        unique case (op)
            OP_PUSH: if (count_q != QMAX) count_d = count_q + CW'(1);
            OP_POP:  if (count_q != '0)   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Queue status must agree with our own occupancy whenever idle.
    always_comb begin
        err_d = err_q;
        if (state_q == IDLE) begin
            if ((pq_empty != (count_q == '0)) ||
                (pq_full != (count_q == QMAX)))
                err_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_pq_stream_adapter.sv
// Self-checking bench for pq_stream_adapter with a behavioural queue
// attached; covers directed vectors, error flag and random traffic.
module tb_pq_stream_adapter;
    import pq_pkg::*;

    localparam int DW = 16;
    localparam int QS = 4;
    localparam int ST = 1;
    localparam int CW = $clog2(QS + 1);

    logic          CLK = 1'b0;
    logic          RSTn = 1'b1;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_data = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic          pq_wrt;
    logic          pq_read;
    logic [DW-1:0] pq_data;
    logic          pq_full = 1'b0;
    logic          pq_empty;
    logic [DW-1:0] pq_head = '0;
    logic [CW-1:0] o_count;
    logic          o_busy;
    logic          o_err;

    logic          force_empty = 1'b0;
    logic          env_clr = 1'b0;
    logic          env_empty = 1'b1;
    logic          wr_l = 1'b0;
    logic          rd_l = 1'b0;
    logic [DW-1:0] dat_l = '0;
    logic [DW-1:0] envq[$];

    int errs = 0;
    int checks = 0;

    typedef struct {
        logic          sv;
        logic          mr;
        logic [DW-1:0] d;
        logic          wrt;
        logic          rd;
        logic          srdy;
        logic          mval;
        logic [DW-1:0] md;
        logic [CW-1:0] cnt;
        logic          busy;
        logic          amv;
        logic [DW-1:0] amd;
    } vec_t;

    vec_t          vt[$];
    logic [DW-1:0] sb[$];
    int            bl;
    bit            e_idle, e_mv, e_pop, e_sr, e_push;

    assign pq_empty = force_empty || env_empty;

    pq_stream_adapter #(
        .DATA_WIDTH    (DW),
        .QUEUE_SIZE    (QS),
        .SETTLE_CYCLES (ST)
    ) dut (
        .CLK      (CLK),
        .RSTn     (RSTn),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .pq_wrt   (pq_wrt),
        .pq_read  (pq_read),
        .pq_data  (pq_data),
        .pq_full  (pq_full),
        .pq_empty (pq_empty),
        .pq_head  (pq_head),
        .o_count  (o_count),
        .o_busy   (o_busy),
        .o_err    (o_err)
    );

    always #5 CLK = ~CLK;

    // Attached queue: commands captured at the edge, applied mid-cycle.
    always @(posedge CLK) begin
        wr_l  <= pq_wrt;
        rd_l  <= pq_read;
        dat_l <= pq_data;
    end

    always @(negedge CLK) begin
        int k;
        if (env_clr) begin
            envq.delete();
        end else begin
            if (rd_l && envq.size() > 0) envq.delete(0);
            if (wr_l) begin
                k = 0;
                while (k < envq.size() && envq[k] <= dat_l) k++;
                envq.insert(k, dat_l);
            end
        end
        env_empty = (envq.size() == 0);
        pq_full   = (envq.size() >= QS);
        pq_head   = (envq.size() > 0) ? envq[0] : '0;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic sv, input logic mr,
                                input int d, input logic wrt,
                                input logic rd, input logic srdy,
                                input logic mval, input int md,
                                input int cnt, input logic busy,
                                input logic amv, input int amd);
        vec_t v;
        v.sv = sv; v.mr = mr; v.d = DW'(d);
        v.wrt = wrt; v.rd = rd; v.srdy = srdy;
        v.mval = mval; v.md = DW'(md);
        v.cnt = CW'(cnt); v.busy = busy;
        v.amv = amv; v.amd = DW'(amd);
        return v;
    endfunction

    task automatic do_reset();
        RSTn    = 1'b0;
        env_clr = 1'b1;
        s_valid = 1'b1;
        s_data  = 16'h0055;
        m_ready = 1'b1;
        #1;
        chk("rst m_valid", m_valid, 0);
        chk("rst m_data", m_data, 0);
        chk("rst pq_wrt", pq_wrt, 0);
        chk("rst pq_read", pq_read, 0);
        chk("rst o_count", o_count, 0);
        chk("rst o_err", o_err, 0);
        chk("rst o_busy", o_busy, 0);
        repeat (2) @(negedge CLK);
        @(negedge CLK);
        RSTn    = 1'b1;
        env_clr = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b0;
    endtask

    task automatic run_vec(input vec_t t, input int i);
        @(negedge CLK);
        s_valid = t.sv;
        m_ready = t.mr;
        s_data  = t.d;
        #2;
        chk($sformatf("v%0d pq_wrt", i), pq_wrt, t.wrt);
        chk($sformatf("v%0d pq_read", i), pq_read, t.rd);
        chk($sformatf("v%0d s_ready", i), s_ready, t.srdy);
        chk($sformatf("v%0d m_valid", i), m_valid, t.mval);
        if (t.wrt) chk($sformatf("v%0d pq_data", i), pq_data, t.d);
        if (t.mval) chk($sformatf("v%0d m_data", i), m_data, t.md);
        @(posedge CLK);
        #1;
        chk($sformatf("v%0d o_count", i), o_count, t.cnt);
        chk($sformatf("v%0d o_busy", i), o_busy, t.busy);
`ifdef PQ_PREFETCH_EN
        chk($sformatf("v%0d m_valid reg", i), m_valid, t.amv);
        if (t.amv) chk($sformatf("v%0d m_data reg", i), m_data, t.amd);
`endif
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "timeout");
    end

    initial begin
        #1;
        do_reset();
`ifndef PQ_PREFETCH_EN
        // push 7,3,9 then pop three
        vt.push_back(mk(1,0,7, 1,0,1,0,0, 1,1, 0,0));
        vt.push_back(mk(1,0,3, 0,0,0,0,0, 1,0, 0,0));
        vt.push_back(mk(1,0,3, 1,0,1,1,7, 2,1, 0,0));
        vt.push_back(mk(1,0,9, 0,0,0,0,0, 2,0, 0,0));
        vt.push_back(mk(1,0,9, 1,0,1,1,3, 3,1, 0,0));
        vt.push_back(mk(0,0,0, 0,0,0,0,0, 3,0, 0,0));
        vt.push_back(mk(0,1,0, 0,1,1,1,3, 2,1, 0,0));
        vt.push_back(mk(0,1,0, 0,0,0,0,0, 2,0, 0,0));
        vt.push_back(mk(0,1,0, 0,1,1,1,7, 1,1, 0,0));
        vt.push_back(mk(0,1,0, 0,0,0,0,0, 1,0, 0,0));
        vt.push_back(mk(0,1,0, 0,1,1,1,9, 0,1, 0,0));
        vt.push_back(mk(0,1,0, 0,0,0,0,0, 0,0, 0,0));
        vt.push_back(mk(0,1,0, 0,0,1,0,0, 0,0, 0,0));
        // fill 5..8, full stall, then replace with 1
        vt.push_back(mk(1,0,5, 1,0,1,0,0, 1,1, 0,0));
        vt.push_back(mk(0,0,0, 0,0,0,0,0, 1,0, 0,0));
        vt.push_back(mk(1,0,6, 1,0,1,1,5, 2,1, 0,0));
        vt.push_back(mk(0,0,0, 0,0,0,0,0, 2,0, 0,0));
        vt.push_back(mk(1,0,7, 1,0,1,1,5, 3,1, 0,0));
        vt.push_back(mk(0,0,0, 0,0,0,0,0, 3,0, 0,0));
        vt.push_back(mk(1,0,8, 1,0,1,1,5, 4,1, 0,0));
        vt.push_back(mk(0,0,0, 0,0,0,0,0, 4,0, 0,0));
        vt.push_back(mk(1,0,1, 0,0,0,1,5, 4,0, 0,0));
        vt.push_back(mk(1,1,1, 1,1,1,1,5, 4,1, 0,0));
        vt.push_back(mk(0,0,0, 0,0,0,0,0, 4,0, 0,0));
        vt.push_back(mk(0,1,0, 0,1,1,1,1, 3,1, 0,0));
        vt.push_back(mk(0,0,0, 0,0,0,0,0, 3,0, 0,0));
        vt.push_back(mk(0,1,0, 0,1,1,1,6, 2,1, 0,0));
        vt.push_back(mk(0,0,0, 0,0,0,0,0, 2,0, 0,0));
        vt.push_back(mk(0,1,0, 0,1,1,1,7, 1,1, 0,0));
        vt.push_back(mk(0,0,0, 0,0,0,0,0, 1,0, 0,0));
        vt.push_back(mk(0,1,0, 0,1,1,1,8, 0,1, 0,0));
        vt.push_back(mk(0,0,0, 0,0,0,0,0, 0,0, 0,0));
        // push and pop together on empty queue: push only
        vt.push_back(mk(1,1,11, 1,0,1,0,0, 1,1, 0,0));
        vt.push_back(mk(0,0,0,  0,0,0,0,0, 1,0, 0,0));
        vt.push_back(mk(0,1,0,  0,1,1,1,11, 0,1, 0,0));
        vt.push_back(mk(0,0,0,  0,0,0,0,0, 0,0, 0,0));
        for (int i = 0; i < vt.size(); i++) run_vec(vt[i], i);
        chk("table o_err", o_err, 0);

        // queue reports empty while two keys are held
        @(negedge CLK); s_valid = 1'b1; s_data = 16'd20;
        @(negedge CLK); s_valid = 1'b0;
        @(negedge CLK); s_valid = 1'b1; s_data = 16'd21;
        @(negedge CLK); s_valid = 1'b0;
        @(posedge CLK); #1;
        chk("err pre o_count", o_count, 2);
        @(negedge CLK);
        force_empty = 1'b1;
        #2;
        chk("err before edge", o_err, 0);
        @(posedge CLK); #1;
        chk("err set", o_err, 1);
        repeat (3) @(negedge CLK);
        force_empty = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("err sticky", o_err, 1);
        do_reset();

        // random traffic against an occupancy/ordering model
        bl = 0;
        sb.delete();
        for (int c = 0; c < 400; c++) begin
            @(negedge CLK);
            s_valid = ($urandom % 3) != 0;
            m_ready = ($urandom % 2) == 0;
            s_data  = DW'($urandom_range(0, 40));
            e_idle = (bl == 0);
            e_mv   = e_idle && (sb.size() > 0);
            e_pop  = e_mv && m_ready;
            e_sr   = e_idle && ((sb.size() < QS) || e_pop);
            e_push = s_valid && e_sr;
            #2;
            chk("rnd m_valid", m_valid, e_mv);
            chk("rnd s_ready", s_ready, e_sr);
            chk("rnd pq_wrt", pq_wrt, e_push);
            chk("rnd pq_read", pq_read, e_pop);
            chk("rnd o_busy", o_busy, !e_idle);
            if (e_mv) chk("rnd m_data", m_data, sb[0]);
            if (e_pop) sb.delete(0);
            if (e_push) begin
                int k;
                k = 0;
                while (k < sb.size() && sb[k] <= s_data) k++;
                sb.insert(k, s_data);
            end
            if (e_push || e_pop) bl = ST;
            else if (bl > 0) bl--;
            @(posedge CLK); #1;
            chk("rnd o_count", o_count, 32'(sb.size()));
            chk("rnd o_err", o_err, 0);
        end
`else
        // push 4, prefetch it, push 2 behind it, release
        vt.push_back(mk(1,0,4, 1,0,1,0,0, 1,1, 0,0));
        vt.push_back(mk(0,0,0, 0,0,0,0,0, 1,0, 0,0));
        vt.push_back(mk(0,0,0, 0,1,1,0,0, 0,1, 1,4));
        vt.push_back(mk(1,0,2, 0,0,0,1,4, 0,0, 1,4));
        vt.push_back(mk(1,0,2, 1,0,1,1,4, 1,1, 1,4));
        vt.push_back(mk(0,0,0, 0,0,0,1,4, 1,0, 1,4));
        vt.push_back(mk(0,0,0, 0,0,1,1,4, 1,0, 1,4));
        vt.push_back(mk(0,1,0, 0,1,1,1,4, 0,1, 1,2));
        vt.push_back(mk(0,1,0, 0,0,0,1,2, 0,0, 0,0));
        vt.push_back(mk(1,0,9, 1,0,1,0,0, 1,1, 0,0));
        for (int i = 0; i < vt.size(); i++) run_vec(vt[i], i);
        chk("pf o_err", o_err, 0);
        chk("pf busy pre-reset", o_busy, 1);
        do_reset();
`endif
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
